// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: state encoding,
// digit widths and default digit moduli.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int TENS_W  = 3;
    localparam int UNITS_W = 4;

    localparam int DEF_SEC_U_MOD = 10;
    localparam int DEF_SEC_T_MOD = 6;
    localparam int DEF_MIN_U_MOD = 10;
    localparam int DEF_MIN_T_MOD = 6;

endpackage

// File: rtl/bcd_down_digit.sv
// One down-counting modulo-n digit with a saturating preset load and a
// combinational borrow that enables the next more significant digit.
module bcd_down_digit #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             borrow_out
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] load_sat;

    // Out-of-range presets clamp to the largest legal digit.
    always_comb begin
        load_sat = (load_val > TOP) ? TOP : load_val;
    end

    assign borrow_out = en && (value == '0);

    // Digit register: reset, preset load, or decrement with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_sat;
        end else if (en) begin
            value <= (value == '0) ? TOP : value - WIDTH'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_mmss.sv
// MM:SS countdown timer: four chained BCD down-digits plus the control FSM
// that handles load/start/pause, one-second decrements and expiry.
module countdown_timer_mmss
    import timer_pkg::*;
#(
    parameter int SEC_U_MOD = DEF_SEC_U_MOD,
    parameter int SEC_T_MOD = DEF_SEC_T_MOD,
    parameter int MIN_U_MOD = DEF_MIN_U_MOD,
    parameter int MIN_T_MOD = DEF_MIN_T_MOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [2:0] set_min_t,
    input  logic [3:0] set_min_u,
    input  logic [2:0] set_sec_t,
    input  logic [3:0] set_sec_u,
    input  logic       start,
    input  logic       pause,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       expired,
    output logic       done
);

    state_t state;

    logic load_en;
    logic dec_en;
    logic sec_u_borrow;
    logic sec_t_borrow;
    logic min_u_borrow;
    logic unused_min_t_borrow;
    logic count_zero;
    logic hits_zero;

    // Load is ignored while running; pause outranks tick in the same cycle.
    always_comb begin
        load_en    = load && (state != RUN);
        dec_en     = tick && (state == RUN) && !pause;
        count_zero = (min_t == '0) && (min_u == '0) && (sec_t == '0) && (sec_u == '0);
        hits_zero  = dec_en && (min_t == '0) && (min_u == '0) && (sec_t == '0)
                     && (sec_u == UNITS_W'(1));
    end

    bcd_down_digit #(.WIDTH(UNITS_W), .MODULUS(SEC_U_MOD)) u_sec_u (
        .clk        (clk),
        .reset      (reset),
        .load       (load_en),
        .load_val   (set_sec_u),
        .en         (dec_en),
        .value      (sec_u),
        .borrow_out (sec_u_borrow)
    );

    bcd_down_digit #(.WIDTH(TENS_W), .MODULUS(SEC_T_MOD)) u_sec_t (
        .clk        (clk),
        .reset      (reset),
        .load       (load_en),
        .load_val   (set_sec_t),
        .en         (sec_u_borrow),
        .value      (sec_t),
        .borrow_out (sec_t_borrow)
    );

    bcd_down_digit #(.WIDTH(UNITS_W), .MODULUS(MIN_U_MOD)) u_min_u (
        .clk        (clk),
        .reset      (reset),
        .load       (load_en),
        .load_val   (set_min_u),
        .en         (sec_t_borrow),
        .value      (min_u),
        .borrow_out (min_u_borrow)
    );

    bcd_down_digit #(.WIDTH(TENS_W), .MODULUS(MIN_T_MOD)) u_min_t (
        .clk        (clk),
        .reset      (reset),
        .load       (load_en),
        .load_val   (set_min_t),
        .en         (min_u_borrow),
        .value      (min_t),
        .borrow_out (unused_min_t_borrow)
    );

    // Control FSM with registered running/expired/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, PAUSED: begin
                    if (load) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        expired <= 1'b0;
                    end else if (start && !count_zero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else if (hits_zero) begin
                        state   <= EXPIRED;
                        running <= 1'b0;
                        expired <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                EXPIRED: begin
                    if (load) begin
                        state   <= IDLE;
                        expired <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Scoreboard bench for countdown_timer_mmss: stimulus queues expected
// outputs after each clock edge; a monitor compares them at the falling edge.
module tb_countdown_timer_mmss;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       load;
    logic [2:0] set_min_t;
    logic [3:0] set_min_u;
    logic [2:0] set_sec_t;
    logic [3:0] set_sec_u;
    logic       start;
    logic       pause;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
    logic       running;
    logic       expired;
    logic       done;

    typedef struct packed {
        logic [2:0]  mt;
        logic [3:0]  mu;
        logic [2:0]  st;
        logic [3:0]  su;
        logic        run;
        logic        exp;
        logic        dn;
        logic [31:0] dcnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int compared   = 0;
    int mismatched = 0;
    int done_seen  = 0;

    countdown_timer_mmss #(
        .SEC_U_MOD(10),
        .SEC_T_MOD(6),
        .MIN_U_MOD(10),
        .MIN_T_MOD(6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .load      (load),
        .set_min_t (set_min_t),
        .set_min_u (set_min_u),
        .set_sec_t (set_sec_t),
        .set_sec_u (set_sec_u),
        .start     (start),
        .pause     (pause),
        .min_t     (min_t),
        .min_u     (min_u),
        .sec_t     (sec_t),
        .sec_u     (sec_u),
        .running   (running),
        .expired   (expired),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: tally done pulses, then drain and check queued expectations.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (done) done_seen++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compared++;
            if (min_t !== e.mt || min_u !== e.mu || sec_t !== e.st || sec_u !== e.su ||
                running !== e.run || expired !== e.exp || done !== e.dn ||
                done_seen != int'(e.dcnt)) begin
                mismatched++;
                $display("FAIL %s: got %0d%0d:%0d%0d run=%0b exp=%0b done=%0b pulses=%0d, want %0d%0d:%0d%0d run=%0b exp=%0b done=%0b pulses=%0d",
                         n, min_t, min_u, sec_t, sec_u, running, expired, done, done_seen,
                         e.mt, e.mu, e.st, e.su, e.run, e.exp, e.dn, e.dcnt);
            end
        end
    end

    task automatic step(input logic l, input logic s, input logic p, input logic t);
        load  = l;
        start = s;
        pause = p;
        tick  = t;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic preset(input int mt, input int mu, input int st, input int su);
        set_min_t = 3'(mt);
        set_min_u = 4'(mu);
        set_sec_t = 3'(st);
        set_sec_u = 4'(su);
    endtask

    task automatic expect_out(input string nm, input int mt, input int mu, input int st,
                              input int su, input logic run, input logic ex,
                              input logic dn, input int dcnt);
        exp_t e;
        e.mt   = 3'(mt);
        e.mu   = 4'(mu);
        e.st   = 3'(st);
        e.su   = 4'(su);
        e.run  = run;
        e.exp  = ex;
        e.dn   = dn;
        e.dcnt = 32'(dcnt);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        preset(0, 0, 0, 0);
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        idle(2);
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // 00:03 countdown to expiry
        preset(0, 0, 0, 3);
        step(1, 0, 0, 0); expect_out("load_0003", 0, 0, 0, 3, 0, 0, 0, 0);
        step(0, 1, 0, 0); expect_out("start_0003", 0, 0, 0, 3, 1, 0, 0, 0);
        idle(4);
        step(0, 0, 0, 1); expect_out("tick1_0002", 0, 0, 0, 2, 1, 0, 0, 0);
        idle(4);
        step(0, 0, 0, 1); expect_out("tick2_0001", 0, 0, 0, 1, 1, 0, 0, 0);
        idle(4);
        step(0, 0, 0, 1); expect_out("tick3_expire", 0, 0, 0, 0, 0, 1, 1, 1);
        idle(1);          expect_out("done_one_cycle", 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1); expect_out("expired_tick_hold", 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 1, 0, 0); expect_out("expired_start_ign", 0, 0, 0, 0, 0, 1, 0, 1);
        preset(0, 0, 0, 5);
        step(1, 0, 0, 0); expect_out("expired_load_0005", 0, 0, 0, 5, 0, 0, 0, 1);

        // 10:00 borrow chain and load ignored in RUN
        preset(1, 0, 0, 0);
        step(1, 0, 0, 0); expect_out("load_1000", 1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0); expect_out("start_1000", 1, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1); expect_out("tick_0959", 0, 9, 5, 9, 1, 0, 0, 1);
        preset(0, 5, 3, 0);
        step(1, 0, 0, 0); expect_out("load_in_run_ign", 0, 9, 5, 9, 1, 0, 0, 1);
        step(0, 0, 1, 0); expect_out("pause_0959", 0, 9, 5, 9, 0, 0, 0, 1);

        // pause beats tick; tick while paused ignored
        preset(0, 1, 0, 0);
        step(1, 0, 0, 0); expect_out("load_0100", 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0); expect_out("start_0100", 0, 1, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1); expect_out("pause_tick_same", 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1); expect_out("tick_paused", 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0); expect_out("resume", 0, 1, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1); expect_out("tick_0059", 0, 0, 5, 9, 1, 0, 0, 1);
        step(0, 0, 1, 0); expect_out("pause_0059", 0, 0, 5, 9, 0, 0, 0, 1);

        // saturating preset and full 59:59 run-down
        preset(7, 15, 6, 10);
        step(1, 0, 0, 0); expect_out("load_sat_5959", 5, 9, 5, 9, 0, 0, 0, 1);
        step(0, 1, 0, 0); expect_out("start_5959", 5, 9, 5, 9, 1, 0, 0, 1);
        for (int i = 1; i <= 3599; i++) begin
            step(0, 0, 0, 1);
            r = 3599 - i;
            expect_out("full_run", (r / 60) / 10, (r / 60) % 10, (r % 60) / 10, r % 10,
                       (r != 0), (r == 0), (r == 0), (r == 0) ? 2 : 1);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1); expect_out("no_wrap", 0, 0, 0, 0, 0, 1, 0, 2);
        end

        // start with 00:00 ignored
        preset(0, 0, 0, 0);
        step(1, 0, 0, 0); expect_out("load_0000", 0, 0, 0, 0, 0, 0, 0, 2);
        step(0, 1, 0, 0); expect_out("start_zero_ign", 0, 0, 0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 1); expect_out("tick_idle_hold", 0, 0, 0, 0, 0, 0, 0, 2);

        // reset during RUN
        preset(0, 2, 0, 0);
        step(1, 0, 0, 0); expect_out("load_0200", 0, 2, 0, 0, 0, 0, 0, 2);
        step(0, 1, 0, 0); expect_out("start_0200", 0, 2, 0, 0, 1, 0, 0, 2);
        step(0, 0, 0, 1); expect_out("tick_0159", 0, 1, 5, 9, 1, 0, 0, 2);
        step(0, 0, 0, 1); expect_out("tick_0158", 0, 1, 5, 8, 1, 0, 0, 2);
        reset = 1'b1;
        step(0, 0, 0, 1); expect_out("reset_in_run", 0, 0, 0, 0, 0, 0, 0, 2);
        reset = 1'b0;
        idle(2);          expect_out("after_reset", 0, 0, 0, 0, 0, 0, 0, 2);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
